// File: rtl/rc4_keystream_decrypt_pkg.sv
// Shared types for the RC4 engine: PRGA decrypt states, key-schedule states
// and the fixed per-byte cycle count of the decrypt loop.
package rc4_keystream_decrypt_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        I_ADDR = 4'd1,
        SI_LAT = 4'd2,
        J_ADDR = 4'd3,
        SJ_LAT = 4'd4,
        WR_I   = 4'd5,
        WR_J   = 4'd6,
        F_ADDR = 4'd7,
        F_LAT  = 4'd8,
        WR_DEC = 4'd9
    } prga_state_e;

    typedef enum logic [1:0] {
        KSA_IDLE    = 2'd0,
        KSA_FILL    = 2'd1,
        KSA_SHUFFLE = 2'd2,
        KSA_DONE    = 2'd3
    } ksa_state_e;

    localparam int unsigned PRGA_BYTE_CYCLES = 32'd9;

endpackage

// File: rtl/rc4_keystream_decrypt.sv
// RC4 PRGA decrypter: walks an already-shuffled S-box in external RAM and
// XORs the keystream onto the encrypted ROM, writing plaintext to a RAM.
module rc4_keystream_decrypt
    import rc4_keystream_decrypt_pkg::*;
#(
    parameter int RAM_WIDTH  = 8,
    parameter int MSG_LENGTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_sig,
    input  logic [RAM_WIDTH-1:0]          s_rdata,
    output logic [RAM_WIDTH-1:0]          s_addr,
    output logic [RAM_WIDTH-1:0]          s_wdata,
    output logic                          s_we,
    input  logic [RAM_WIDTH-1:0]          msg_rdata,
    output logic [$clog2(MSG_LENGTH)-1:0] msg_addr,
    output logic [$clog2(MSG_LENGTH)-1:0] dec_addr,
    output logic [RAM_WIDTH-1:0]          dec_wdata,
    output logic                          dec_we,
    output logic                          busy,
    output logic                          decrypt_finished
);

    localparam int AW = $clog2(MSG_LENGTH);
    localparam logic [AW-1:0]        K_LAST = AW'(MSG_LENGTH - 1);
    localparam logic [AW-1:0]        ONE_K  = AW'(1);
    localparam logic [RAM_WIDTH-1:0] ONE_B  = RAM_WIDTH'(1);
    localparam logic [RAM_WIDTH-1:0] ZERO_B = RAM_WIDTH'(0);
    localparam logic [AW-1:0]        ZERO_K = AW'(0);

    prga_state_e          state_q, state_d;
    logic [RAM_WIDTH-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [RAM_WIDTH-1:0] f_q, f_d, enc_q, enc_d;
    logic [AW-1:0]        k_q, k_d;

    logic [RAM_WIDTH-1:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic [RAM_WIDTH-1:0] dec_wdata_q, dec_wdata_d;
    logic [AW-1:0]        msg_addr_q, msg_addr_d, dec_addr_q, dec_addr_d;
    logic                 s_we_q, s_we_d, dec_we_q, dec_we_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        enc_d   = enc_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start_sig) begin
                    state_d = I_ADDR;
                    i_d     = ZERO_B;
                    j_d     = ZERO_B;
                    k_d     = ZERO_K;
                    done_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            I_ADDR: begin
                i_d     = i_q + ONE_B;
                state_d = SI_LAT;
            end
            SI_LAT: begin
                si_d    = s_rdata;
                state_d = J_ADDR;
            end
            J_ADDR: begin
                j_d     = j_q + si_q;
                state_d = SJ_LAT;
            end
            SJ_LAT: begin
                sj_d    = s_rdata;
                state_d = WR_I;
            end
            WR_I:   state_d = WR_J;
            WR_J:   state_d = F_ADDR;
            F_ADDR: state_d = F_LAT;
            F_LAT: begin
                f_d     = s_rdata;
                enc_d   = msg_rdata;
                state_d = WR_DEC;
            end
            WR_DEC: begin
                if (k_q == K_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    k_d     = k_q + ONE_K;
                    state_d = I_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered by decoding the state about to be entered, so
    // they appear during that state exactly as a combinational decode would.
    always_comb begin
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_we_d      = 1'b0;
        msg_addr_d  = msg_addr_q;
        dec_addr_d  = dec_addr_q;
        dec_wdata_d = dec_wdata_q;
        dec_we_d    = 1'b0;
        busy_d      = (state_d != IDLE);
        case (state_d)
            I_ADDR: s_addr_d = i_d + ONE_B;
            J_ADDR: s_addr_d = j_d + si_d;
            WR_I: begin
                s_addr_d  = i_d;
                s_wdata_d = sj_d;
                s_we_d    = 1'b1;
            end
            WR_J: begin
                s_addr_d  = j_d;
                s_wdata_d = si_d;
                s_we_d    = 1'b1;
            end
            F_ADDR: begin
                s_addr_d   = si_d + sj_d;
                msg_addr_d = k_d;
            end
            WR_DEC: begin
                dec_addr_d  = k_d;
                dec_wdata_d = f_d ^ enc_d;
                dec_we_d    = 1'b1;
            end
            default: begin
                s_we_d   = 1'b0;
                dec_we_d = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            i_q         <= ZERO_B;
            j_q         <= ZERO_B;
            k_q         <= ZERO_K;
            si_q        <= ZERO_B;
            sj_q        <= ZERO_B;
            f_q         <= ZERO_B;
            enc_q       <= ZERO_B;
            s_addr_q    <= ZERO_B;
            s_wdata_q   <= ZERO_B;
            s_we_q      <= 1'b0;
            msg_addr_q  <= ZERO_K;
            dec_addr_q  <= ZERO_K;
            dec_wdata_q <= ZERO_B;
            dec_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            f_q         <= f_d;
            enc_q       <= enc_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_we_q      <= s_we_d;
            msg_addr_q  <= msg_addr_d;
            dec_addr_q  <= dec_addr_d;
            dec_wdata_q <= dec_wdata_d;
            dec_we_q    <= dec_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_addr           = s_addr_q;
    assign s_wdata          = s_wdata_q;
    assign s_we             = s_we_q;
    assign msg_addr         = msg_addr_q;
    assign dec_addr         = dec_addr_q;
    assign dec_wdata        = dec_wdata_q;
    assign dec_we           = dec_we_q;
    assign busy             = busy_q;
    assign decrypt_finished = done_q;

endmodule

// File: tb/tb_rc4_keystream_decrypt.sv
// Bench for rc4_keystream_decrypt: a 3-byte and a 32-byte instance with RAM/ROM
// models, checked against a plain-arithmetic RC4 reference.
module tb_rc4_keystream_decrypt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b, load_a, load_b, sel_b;

    logic [7:0] s_rdata_a, s_addr_a, s_wdata_a, msg_rdata_a, dec_wdata_a;
    logic [1:0] msg_addr_a, dec_addr_a;
    logic       s_we_a, dec_we_a, busy_a, done_a;
    logic [7:0] s_rdata_b, s_addr_b, s_wdata_b, msg_rdata_b, dec_wdata_b;
    logic [4:0] msg_addr_b, dec_addr_b;
    logic       s_we_b, dec_we_b, busy_b, done_b;

    logic [7:0] preset_s [256];
    logic [7:0] msg_img  [32];
    logic [7:0] sbox_a [256];
    logic [7:0] sbox_b [256];
    logic [7:0] dec_a  [4];
    logic [7:0] dec_b  [32];
    logic [7:0] mdl_s  [256];
    logic [7:0] mdl_dec [32];

    int checks = 0;
    int errors = 0;

    rc4_keystream_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(3)) dut_a (
        .clk(clk), .reset(reset), .start_sig(start_a),
        .s_rdata(s_rdata_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_we(s_we_a),
        .msg_rdata(msg_rdata_a), .msg_addr(msg_addr_a),
        .dec_addr(dec_addr_a), .dec_wdata(dec_wdata_a), .dec_we(dec_we_a),
        .busy(busy_a), .decrypt_finished(done_a)
    );

    rc4_keystream_decrypt #(.RAM_WIDTH(8), .MSG_LENGTH(32)) dut_b (
        .clk(clk), .reset(reset), .start_sig(start_b),
        .s_rdata(s_rdata_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_we(s_we_b),
        .msg_rdata(msg_rdata_b), .msg_addr(msg_addr_b),
        .dec_addr(dec_addr_b), .dec_wdata(dec_wdata_b), .dec_we(dec_we_b),
        .busy(busy_b), .decrypt_finished(done_b)
    );

    // Synchronous S-box RAM, message ROM and plaintext RAM for instance A.
    always @(posedge clk) begin
        if (load_a) begin
            for (int n = 0; n < 256; n++) sbox_a[n] <= preset_s[n];
            for (int n = 0; n < 4; n++) dec_a[n] <= 8'h00;
        end else begin
            if (s_we_a) sbox_a[s_addr_a] <= s_wdata_a;
            if (dec_we_a) dec_a[dec_addr_a] <= dec_wdata_a;
        end
        s_rdata_a   <= sbox_a[s_addr_a];
        msg_rdata_a <= msg_img[{3'b000, msg_addr_a}];
    end

    // Same memory set for instance B.
    always @(posedge clk) begin
        if (load_b) begin
            for (int n = 0; n < 256; n++) sbox_b[n] <= preset_s[n];
            for (int n = 0; n < 32; n++) dec_b[n] <= 8'h00;
        end else begin
            if (s_we_b) sbox_b[s_addr_b] <= s_wdata_b;
            if (dec_we_b) dec_b[dec_addr_b] <= dec_wdata_b;
        end
        s_rdata_b   <= sbox_b[s_addr_b];
        msg_rdata_b <= msg_img[msg_addr_b];
    end

    logic       obs_s_we, obs_dec_we, obs_done;
    logic [7:0] obs_s_addr;
    logic [4:0] obs_dec_addr;
    assign obs_s_we     = sel_b ? s_we_b : s_we_a;
    assign obs_dec_we   = sel_b ? dec_we_b : dec_we_a;
    assign obs_done     = sel_b ? done_b : done_a;
    assign obs_s_addr   = sel_b ? s_addr_b : s_addr_a;
    assign obs_dec_addr = sel_b ? dec_addr_b : {3'b000, dec_addr_a};

    // Reference RC4 PRGA over preset_s/msg_img; leaves final S in mdl_s.
    task automatic model_prga(input int ml);
        int i;
        int j;
        logic [7:0] t;
        i = 0;
        j = 0;
        for (int n = 0; n < 256; n++) mdl_s[n] = preset_s[n];
        for (int k = 0; k < ml; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(mdl_s[i])) % 256;
            t = mdl_s[i];
            mdl_s[i] = mdl_s[j];
            mdl_s[j] = t;
            mdl_dec[k] = mdl_s[(int'(mdl_s[i]) + int'(mdl_s[j])) % 256] ^ msg_img[k];
        end
    endtask

    task automatic random_perm();
        int r;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) preset_s[n] = 8'(n);
        for (int n = 255; n > 0; n--) begin
            r = int'($urandom_range(n, 0));
            t = preset_s[n];
            preset_s[n] = preset_s[r];
            preset_s[r] = t;
        end
    endtask

    task automatic random_msg();
        for (int n = 0; n < 32; n++) msg_img[n] = 8'($urandom);
    endtask

    task automatic load_images(input bit to_b);
        @(negedge clk);
        if (to_b) load_b = 1'b1;
        else      load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    // Starts one run and gathers observations; callers do the comparing.
    task automatic run(input bit to_b, input int pulse_at, output int cyc,
                       output int both, output int seq_bad, output int swe_n,
                       output int dwe_n, output logic [7:0] addr_wrj,
                       output logic [7:0] addr_f);
        int exp_k;
        sel_b = to_b;
        cyc = -1; both = 0; seq_bad = 0; swe_n = 0; dwe_n = 0; exp_k = 0;
        addr_wrj = 8'h00; addr_f = 8'h00;
        @(negedge clk);
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            if (c == pulse_at) begin
                if (to_b) start_b = 1'b1;
                else      start_a = 1'b1;
            end
            if (c == 6) addr_wrj = obs_s_addr;
            if (c == 7) addr_f = obs_s_addr;
            if (obs_s_we && obs_dec_we) both++;
            if (obs_s_we) swe_n++;
            if (obs_dec_we) begin
                if (int'(obs_dec_addr) != exp_k) seq_bad++;
                exp_k++;
                dwe_n++;
            end
            if (obs_done) begin
                cyc = c;
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] va;
        logic [63:0] vb;
        reset = 1'b1;
        #1 reset = 1'b0;
        #11;
        va = {s_addr_a, s_wdata_a, s_we_a, msg_addr_a, dec_addr_a, dec_wdata_a, dec_we_a, busy_a, done_a};
        vb = {26'd0, s_addr_b, s_wdata_b, s_we_b, msg_addr_b, dec_addr_b, dec_wdata_b, dec_we_b, busy_b, done_b};
        checks++;
        if (va !== 32'd0) begin errors++; $display("FAIL reset_a: got %h want 0", va); end
        checks++;
        if (vb !== 64'd0) begin errors++; $display("FAIL reset_b: got %h want 0", vb); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_known(input bit ff_msg);
        int cyc, both, seq_bad, swe_n, dwe_n;
        logic [7:0] aw, af;
        logic [7:0] exp_dec [3];
        for (int n = 0; n < 256; n++) preset_s[n] = 8'(n);
        for (int n = 0; n < 32; n++) msg_img[n] = ff_msg ? 8'hFF : 8'h00;
        if (ff_msg) exp_dec = '{8'hFD, 8'hFA, 8'hF8};
        else        exp_dec = '{8'h02, 8'h05, 8'h07};
        load_images(1'b0);
        run(1'b0, 0, cyc, both, seq_bad, swe_n, dwe_n, aw, af);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dec_a[k] !== exp_dec[k]) begin
                errors++; $display("FAIL known_dec[%0d] ff=%0d: got %h want %h", k, ff_msg, dec_a[k], exp_dec[k]);
            end
        end
        checks++;
        if ({sbox_a[2], sbox_a[3], sbox_a[5]} !== 24'h030502) begin
            errors++; $display("FAIL known_sbox: got %h %h %h want 03 05 02", sbox_a[2], sbox_a[3], sbox_a[5]);
        end
        checks++;
        if (cyc != 28) begin errors++; $display("FAIL latency: got %0d want 28", cyc); end
        checks++;
        if (both != 0 || swe_n != 6 || dwe_n != 3 || seq_bad != 0) begin
            errors++; $display("FAIL strobes: both=%0d swe=%0d dwe=%0d seqbad=%0d want 0 6 3 0", both, swe_n, dwe_n, seq_bad);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL done_hold: done=%b busy=%b want 1 0", done_a, busy_a);
        end
    endtask

    task automatic check_run_a(input string name, input int cyc_exp, input int pulse_at);
        int cyc, both, seq_bad, swe_n, dwe_n;
        logic [7:0] aw, af;
        model_prga(3);
        run(1'b0, pulse_at, cyc, both, seq_bad, swe_n, dwe_n, aw, af);
        checks++;
        if ({dec_a[0], dec_a[1], dec_a[2]} !== {mdl_dec[0], mdl_dec[1], mdl_dec[2]}) begin
            errors++; $display("FAIL %s dec: got %h%h%h want %h%h%h", name, dec_a[0], dec_a[1], dec_a[2], mdl_dec[0], mdl_dec[1], mdl_dec[2]);
        end
        checks++;
        if (cyc != cyc_exp || seq_bad != 0 || both != 0) begin
            errors++; $display("FAIL %s timing: cyc=%0d seqbad=%0d both=%0d want %0d 0 0", name, cyc, seq_bad, both, cyc_exp);
        end
    endtask

    task automatic test_random_short();
        for (int it = 0; it < 3; it++) begin
            random_perm();
            random_msg();
            load_images(1'b0);
            check_run_a("random_short", 28, 0);
        end
    endtask

    task automatic test_wrap();
        int cyc, both, seq_bad, swe_n, dwe_n, p;
        logic [7:0] aw, af, t, exp_f;
        random_perm();
        random_msg();
        p = 0;
        for (int n = 0; n < 256; n++) if (preset_s[n] == 8'hFF) p = n;
        t = preset_s[1];
        preset_s[1] = preset_s[p];
        preset_s[p] = t;
        exp_f = 8'(int'(preset_s[255]) + 255);
        model_prga(3);
        load_images(1'b0);
        run(1'b0, 0, cyc, both, seq_bad, swe_n, dwe_n, aw, af);
        checks++;
        if (aw !== 8'hFF) begin errors++; $display("FAIL wrap_j: got %h want ff", aw); end
        checks++;
        if (af !== exp_f) begin errors++; $display("FAIL wrap_faddr: got %h want %h", af, exp_f); end
        checks++;
        if ({dec_a[0], dec_a[1], dec_a[2]} !== {mdl_dec[0], mdl_dec[1], mdl_dec[2]}) begin
            errors++; $display("FAIL wrap_dec: got %h%h%h want %h%h%h", dec_a[0], dec_a[1], dec_a[2], mdl_dec[0], mdl_dec[1], mdl_dec[2]);
        end
    endtask

    task automatic test_start_while_busy();
        random_perm();
        random_msg();
        load_images(1'b0);
        check_run_a("busy_start", 28, 10);
    endtask

    task automatic test_reset_mid();
        logic [31:0] va;
        random_perm();
        random_msg();
        load_images(1'b0);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (13) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        va = {s_addr_a, s_wdata_a, s_we_a, msg_addr_a, dec_addr_a, dec_wdata_a, dec_we_a, busy_a, done_a};
        checks++;
        if (va !== 32'd0) begin errors++; $display("FAIL reset_mid: got %h want 0", va); end
        @(negedge clk);
        reset = 1'b1;
        load_images(1'b0);
        check_run_a("after_reset", 28, 0);
    endtask

    task automatic test_ksa_32();
        int cyc, both, seq_bad, swe_n, dwe_n, j;
        logic [7:0] aw, af, t;
        logic [7:0] key [3];
        logic [7:0] pt [32];
        int bad;
        key = '{8'h00, 8'h02, 8'h49};
        for (int n = 0; n < 256; n++) preset_s[n] = 8'(n);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(preset_s[i]) + int'(key[i % 3])) % 256;
            t = preset_s[i];
            preset_s[i] = preset_s[j];
            preset_s[j] = t;
        end
        for (int n = 0; n < 32; n++) msg_img[n] = 8'h00;
        model_prga(32);
        for (int n = 0; n < 32; n++) begin
            pt[n] = 8'($urandom_range(126, 32));
            msg_img[n] = pt[n] ^ mdl_dec[n];
        end
        load_images(1'b1);
        run(1'b1, 0, cyc, both, seq_bad, swe_n, dwe_n, aw, af);
        bad = 0;
        for (int n = 0; n < 32; n++) if (dec_b[n] !== pt[n]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ksa32_dec: %0d bytes wrong, byte0 got %h want %h", bad, dec_b[0], pt[0]); end
        bad = 0;
        for (int n = 0; n < 256; n++) if (sbox_b[n] !== mdl_s[n]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ksa32_sbox: %0d entries differ want 0", bad); end
        checks++;
        if (cyc != 289 || swe_n != 64 || dwe_n != 32 || both != 0 || seq_bad != 0) begin
            errors++; $display("FAIL ksa32_timing: cyc=%0d swe=%0d dwe=%0d both=%0d seqbad=%0d want 289 64 32 0 0", cyc, swe_n, dwe_n, both, seq_bad);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, both, seq_bad, swe_n, dwe_n, bad;
        logic [7:0] aw, af;
        random_perm();
        load_images(1'b1);
        for (int r = 0; r < 2; r++) begin
            random_msg();
            model_prga(32);
            run(1'b1, 0, cyc, both, seq_bad, swe_n, dwe_n, aw, af);
            bad = 0;
            for (int n = 0; n < 32; n++) if (dec_b[n] !== mdl_dec[n]) bad++;
            checks++;
            if (bad != 0 || cyc != 289) begin
                errors++; $display("FAIL back_to_back[%0d]: %0d bytes wrong cyc=%0d want 0 289", r, bad, cyc);
            end
            for (int n = 0; n < 256; n++) preset_s[n] = mdl_s[n];
        end
    endtask

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        sel_b   = 1'b0;
        for (int n = 0; n < 32; n++) msg_img[n] = 8'h00;
        for (int n = 0; n < 256; n++) preset_s[n] = 8'(n);
        test_reset();
        test_known(1'b0);
        test_known(1'b1);
        test_random_short();
        test_wrap();
        test_start_while_busy();
        test_reset_mid();
        test_ksa_32();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
